// File: rtl/axi_wr_sink.sv
// Memory-backed AXI write responder with programmable stall and statistics registers.
// Latency: RAM write and werr 1 cycle after beat acceptance; reg ack 1 cycle, RAM readback ack 2 cycles.
// Backpressure: wrdy registered; high in IDLE when enabled and through a burst, low for STALL cycles after it.
module axi_wr_sink #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_AW    = 10
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic [31:0] axi_waddr_i,
    input  logic [63:0] axi_wdata_i,
    input  logic [7:0]  axi_wsel_i,
    input  logic        axi_wvalid_i,
    input  logic [3:0]  axi_wlen_i,
    input  logic        axi_wfixed_i,
    output logic        axi_wrdy_o,
    output logic        axi_werr_o,
    input  logic [31:0] sys_addr_i,
    input  logic [31:0] sys_wdata_i,
    input  logic        sys_wen_i,
    input  logic        sys_ren_i,
    output logic [31:0] sys_rdata_o,
    output logic        sys_err_o,
    output logic        sys_ack_o
);
    localparam logic [19:0] MEM_OFFSET = 20'h10000;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_STALL} state_t;

    state_t      state_q, state_d;
    logic        wrdy_d, end_burst, accept;
    logic [3:0]  remain_q;
    logic        fixed_q;
    logic [31:0] cur_addr_q;
    logic [7:0]  stall_cnt_q;

    logic        enable_q, enable_d;
    logic [7:0]  stall_q;
    logic [31:0] beats_q, bursts_q, errors_q, last_addr_q;

    logic [63:0] mem [0:(1 << MEM_AW) - 1];

    logic [31:0]       beat_addr, beat_off;
    logic              beat_in_win;
    logic [MEM_AW-1:0] beat_idx;

    logic [19:0]       off, moff;
    logic              in_mem, ctrl_wr, stall_wr, clr;
    logic [31:0]       reg_rdata;
    logic              rd_pend, rd_hi;
    logic [MEM_AW-1:0] rd_word;
    logic              unused_bits;

    assign accept      = axi_wvalid_i && axi_wrdy_o;
    assign sys_err_o   = 1'b0;
    assign unused_bits = ^{sys_addr_i[31:20], sys_wdata_i[31:8], beat_addr[2:0], moff[1:0]};

    // Address of the current beat: the live waddr on the first beat, the tracked address after that.
    always_comb begin
        beat_addr   = (state_q == S_IDLE) ? axi_waddr_i : cur_addr_q;
        beat_off    = {beat_addr[31:3], 3'b000} - BASE_ADDR;
        beat_in_win = (beat_off >> (MEM_AW + 3)) == 32'd0;
        beat_idx    = beat_off[MEM_AW+2:3];
    end

    // Bus decode: register strobes and the RAM readback window.
    always_comb begin
        off      = sys_addr_i[19:0];
        moff     = off - MEM_OFFSET;
        in_mem   = (off >= MEM_OFFSET) && ((moff >> (MEM_AW + 3)) == 20'd0);
        ctrl_wr  = sys_wen_i && (off == 20'h00000);
        stall_wr = sys_wen_i && (off == 20'h00004);
        clr      = ctrl_wr && sys_wdata_i[1];
        enable_d = ctrl_wr ? sys_wdata_i[0] : enable_q;
    end

    // Next state and next ready; wrdy follows the state being entered so it is registered.
    always_comb begin
        state_d   = state_q;
        wrdy_d    = 1'b0;
        end_burst = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && axi_wlen_i == 4'd0) end_burst = 1'b1;
                else if (accept)                  state_d   = S_BURST;
            end
            S_BURST: if (accept && remain_q == 4'd1) end_burst = 1'b1;
            S_STALL: if (stall_cnt_q <= 8'd1) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (end_burst) state_d = (stall_q != 8'd0) ? S_STALL : S_IDLE;
        case (state_d)
            S_IDLE:  wrdy_d = enable_d;
            S_BURST: wrdy_d = 1'b1;
            default: wrdy_d = 1'b0;
        endcase
    end

    // State register plus burst tracking (remaining beats, running address, stall countdown).
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q     <= S_IDLE;
            remain_q    <= 4'd0;
            fixed_q     <= 1'b0;
            cur_addr_q  <= 32'd0;
            stall_cnt_q <= 8'd0;
            axi_wrdy_o  <= 1'b0;
            axi_werr_o  <= 1'b0;
        end else begin
            state_q    <= state_d;
            axi_wrdy_o <= wrdy_d;
            axi_werr_o <= accept && !beat_in_win;
            if (accept) begin
                if (state_q == S_IDLE) begin
                    remain_q   <= axi_wlen_i;
                    fixed_q    <= axi_wfixed_i;
                    cur_addr_q <= axi_wfixed_i ? axi_waddr_i : axi_waddr_i + 32'd8;
                end else begin
                    remain_q <= remain_q - 4'd1;
                    if (!fixed_q) cur_addr_q <= cur_addr_q + 32'd8;
                end
            end
            if (end_burst)               stall_cnt_q <= stall_q;
            else if (state_q == S_STALL) stall_cnt_q <= stall_cnt_q - 8'd1;
        end
    end

    // Control registers and saturating statistics; a clear beats a same-cycle increment.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            enable_q    <= 1'b0;
            stall_q     <= 8'd0;
            beats_q     <= 32'd0;
            bursts_q    <= 32'd0;
            errors_q    <= 32'd0;
            last_addr_q <= 32'd0;
        end else begin
            enable_q <= enable_d;
            if (stall_wr) stall_q <= sys_wdata_i[7:0];
            if (accept && state_q == S_IDLE) last_addr_q <= axi_waddr_i;
            if (clr) begin
                beats_q  <= 32'd0;
                bursts_q <= 32'd0;
                errors_q <= 32'd0;
            end else begin
                if (accept && beats_q != 32'hFFFF_FFFF) beats_q <= beats_q + 32'd1;
                if (accept && state_q == S_IDLE && bursts_q != 32'hFFFF_FFFF) bursts_q <= bursts_q + 32'd1;
                if (accept && !beat_in_win && errors_q != 32'hFFFF_FFFF) errors_q <= errors_q + 32'd1;
            end
        end
    end

    // Byte-enabled RAM write for in-window beats; contents survive reset.
    always_ff @(posedge sys_clk_i) begin
        if (accept && beat_in_win && !sys_rst_i) begin
            for (int b = 0; b < 8; b++) begin
                if (axi_wsel_i[b]) mem[beat_idx][8*b +: 8] <= axi_wdata_i[8*b +: 8];
            end
        end
    end

    // Register read mux; CTRL clear bit is self-clearing so only enable reads back.
    always_comb begin
        case (off)
            20'h00000: reg_rdata = {31'd0, enable_q};
            20'h00004: reg_rdata = {24'd0, stall_q};
            20'h00008: reg_rdata = beats_q;
            20'h0000C: reg_rdata = bursts_q;
            20'h00010: reg_rdata = errors_q;
            20'h00014: reg_rdata = last_addr_q;
            default:   reg_rdata = 32'd0;
        endcase
    end

    // Bus responder: registers answer next cycle, RAM reads take an extra stage so a same-cycle write is visible.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            sys_ack_o   <= 1'b0;
            sys_rdata_o <= 32'd0;
            rd_pend     <= 1'b0;
            rd_hi       <= 1'b0;
            rd_word     <= '0;
        end else begin
            rd_pend   <= sys_ren_i && in_mem;
            sys_ack_o <= rd_pend || ((sys_wen_i || sys_ren_i) && !(sys_ren_i && in_mem));
            if (sys_ren_i && in_mem) begin
                rd_word <= moff[MEM_AW+2:3];
                rd_hi   <= moff[2];
            end
            if (rd_pend)                    sys_rdata_o <= rd_hi ? mem[rd_word][63:32] : mem[rd_word][31:0];
            else if (sys_ren_i && !in_mem)  sys_rdata_o <= reg_rdata;
        end
    end
endmodule

// File: tb/tb_axi_wr_sink.sv
// Self-checking bench for axi_wr_sink: directed scenarios plus random bursts against a reference model.
// Latency: checks bus acks at 1 (registers) and 2 (RAM) cycles, werr one cycle after each beat.
// Backpressure: measures wrdy stall cycles per beat with a bounded wait.
module tb_axi_wr_sink;
    localparam logic [31:0] BASE = 32'h0800_0000;
    localparam int AW = 10;
    localparam int NW = 1 << AW;

    logic        sys_clk = 1'b0;
    logic        sys_rst_i = 1'b1;
    logic [31:0] axi_waddr = '0;
    logic [63:0] axi_wdata = '0;
    logic [7:0]  axi_wsel = '0;
    logic        axi_wvalid = 1'b0;
    logic [3:0]  axi_wlen = '0;
    logic        axi_wfixed = 1'b0;
    logic        axi_wrdy_o, axi_werr_o;
    logic [31:0] sys_addr = '0, sys_wdata = '0;
    logic        sys_wen = 1'b0, sys_ren = 1'b0;
    logic [31:0] sys_rdata_o;
    logic        sys_err_o, sys_ack_o;

    axi_wr_sink #(.BASE_ADDR(BASE), .MEM_AW(AW)) dut (
        .sys_clk_i(sys_clk), .sys_rst_i(sys_rst_i),
        .axi_waddr_i(axi_waddr), .axi_wdata_i(axi_wdata), .axi_wsel_i(axi_wsel),
        .axi_wvalid_i(axi_wvalid), .axi_wlen_i(axi_wlen), .axi_wfixed_i(axi_wfixed),
        .axi_wrdy_o(axi_wrdy_o), .axi_werr_o(axi_werr_o),
        .sys_addr_i(sys_addr), .sys_wdata_i(sys_wdata), .sys_wen_i(sys_wen), .sys_ren_i(sys_ren),
        .sys_rdata_o(sys_rdata_o), .sys_err_o(sys_err_o), .sys_ack_o(sys_ack_o)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: RAM image and statistics as the specification defines them.
    logic [63:0] ref_mem [NW];
    logic [31:0] m_beats = 0, m_bursts = 0, m_errors = 0, m_last = 0;
    logic        m_en = 0;
    logic [7:0]  m_stall = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_beats = 0; m_bursts = 0; m_errors = 0; m_last = 0; m_en = 0; m_stall = 0;
    endtask

    task automatic bus_write(input logic [19:0] off, input logic [31:0] d);
        sys_addr = {12'd0, off}; sys_wdata = d; sys_wen = 1'b1;
        @(negedge sys_clk);
        sys_wen = 1'b0;
        chk("wr_ack", sys_ack_o, 1);
        if (off == 20'h0) begin
            m_en = d[0];
            if (d[1]) begin m_beats = 0; m_bursts = 0; m_errors = 0; end
        end
        if (off == 20'h4) m_stall = d[7:0];
    endtask

    task automatic bus_read(input logic [19:0] off, output logic [31:0] d, output int lat);
        sys_addr = {12'd0, off}; sys_ren = 1'b1;
        @(negedge sys_clk);
        sys_ren = 1'b0;
        lat = 1;
        while (sys_ack_o !== 1'b1 && lat < 5) begin @(negedge sys_clk); lat++; end
        d = sys_rdata_o;
    endtask

    task automatic rd_reg(input string tag, input logic [19:0] off, input logic [31:0] exp);
        logic [31:0] d; int lat;
        bus_read(off, d, lat);
        chk({tag, "_lat"}, lat, 1);
        chk(tag, d, exp);
    endtask

    task automatic rd_mem(input string tag, input logic [19:0] off, input logic [31:0] exp);
        logic [31:0] d; int lat;
        bus_read(off, d, lat);
        chk({tag, "_lat"}, lat, 2);
        chk(tag, d, exp);
    endtask

    task automatic chk_word(input int idx);
        logic [63:0] w;
        w = ref_mem[idx];
        rd_mem($sformatf("mem%0d_lo", idx), 20'h10000 + 20'(8 * idx), w[31:0]);
        rd_mem($sformatf("mem%0d_hi", idx), 20'h10004 + 20'(8 * idx), w[63:32]);
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                             input logic [3:0] len, input logic fx, output int waited, output bit ok);
        axi_waddr = a; axi_wdata = d; axi_wsel = s; axi_wlen = len; axi_wfixed = fx; axi_wvalid = 1'b1;
        waited = 0;
        while (axi_wrdy_o !== 1'b1 && waited < 64) begin @(negedge sys_clk); waited++; end
        chk("beat_accept", axi_wrdy_o, 1);
        ok = (axi_wrdy_o === 1'b1);
        @(negedge sys_clk);
        axi_wvalid = 1'b0;
    endtask

    // Spec-level effect of one accepted beat at byte address a.
    task automatic model_beat(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                              input bit first, input logic [31:0] start, output bit oob);
        logic [31:0] off;
        off = {a[31:3], 3'b000} - BASE;
        oob = off >= 32'(8 * NW);
        if (!oob) begin
            for (int b = 0; b < 8; b++)
                if (s[b]) ref_mem[off >> 3][8*b +: 8] = d[8*b +: 8];
        end
        m_beats++;
        if (first) begin m_bursts++; m_last = start; end
        if (oob) m_errors++;
    endtask

    // Drive a burst; seq selects data base+i, otherwise random. Returns wait before beat 0 and max later wait.
    task automatic do_burst(input logic [31:0] start, input logic [3:0] len, input logic fx,
                            input bit seq, input logic [63:0] base, input logic [7:0] sel,
                            input bit sel_rand, output int w0, output int wmax);
        logic [63:0] d; logic [7:0] s; logic [31:0] a; int w; bit ok, oob;
        w0 = 0; wmax = 0;
        for (int i = 0; i <= int'(len); i++) begin
            a = fx ? start : start + 32'(8 * i);
            d = seq ? base + 64'(i) : {$urandom, $urandom};
            s = sel_rand ? 8'($urandom) : sel;
            send_beat(start, d, s, len, fx, w, ok);
            if (!ok) return;
            if (i == 0) w0 = w; else if (w > wmax) wmax = w;
            model_beat(a, d, s, i == 0, start, oob);
            chk("werr", axi_werr_o, oob);
        end
    endtask

    task automatic chk_stats(input string tag);
        rd_reg({tag, "_beats"}, 20'h8, m_beats);
        rd_reg({tag, "_bursts"}, 20'hC, m_bursts);
        rd_reg({tag, "_errors"}, 20'h10, m_errors);
        rd_reg({tag, "_last"}, 20'h14, m_last);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, wmax, w1, lat;
        logic [31:0] d, start;
        bit ok, oob;

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_wrdy", axi_wrdy_o, 0);
        chk("rst_werr", axi_werr_o, 0);
        chk("rst_ack", sys_ack_o, 0);
        chk("rst_rdata", sys_rdata_o, 0);
        chk("rst_err", sys_err_o, 0);
        sys_rst_i = 1'b0;
        @(negedge sys_clk);
        rd_reg("rst_ctrl", 20'h0, 0);
        rd_reg("rst_stall", 20'h4, 0);
        chk_stats("rst");
        chk("idle_disabled_rdy", axi_wrdy_o, 0);

        // Fill the whole window with back-to-back full bursts, STALL=0
        bus_write(20'h0, 32'h1);
        chk("enable_rdy", axi_wrdy_o, 1);
        for (int b = 0; b < NW / 16; b++) begin
            do_burst(BASE + 32'(128 * b), 4'd15, 1'b0, 1'b0, 64'd0, 8'hFF, 1'b0, w0, wmax);
            chk("fill_b2b_wait", w0, 0);
            chk("fill_inburst_wait", wmax, 0);
        end
        chk_stats("fill");

        // Burst at 0x20, data 1..4
        bus_write(20'h0, 32'h3);
        do_burst(BASE + 32'h20, 4'd3, 1'b0, 1'b1, 64'd1, 8'hFF, 1'b0, w0, wmax);
        chk("t1_wait", w0 + wmax, 0);
        for (int k = 0; k < 4; k++) begin
            rd_mem("t1_word_lo", 20'h10020 + 20'(8 * k), 32'(k + 1));
            rd_mem("t1_word_hi", 20'h10024 + 20'(8 * k), 32'd0);
        end
        rd_reg("t1_beats", 20'h8, 32'd4);
        rd_reg("t1_bursts", 20'hC, 32'd1);
        rd_reg("t1_last", 20'h14, BASE + 32'h20);
        rd_reg("ctrl_readback", 20'h0, 32'd1);

        // STALL=5 between two single-beat bursts
        bus_write(20'h4, 32'd5);
        do_burst(BASE + 32'h100, 4'd0, 1'b0, 1'b0, 64'd0, 8'hFF, 1'b0, w0, wmax);
        do_burst(BASE + 32'h108, 4'd0, 1'b0, 1'b0, 64'd0, 8'hFF, 1'b0, w1, wmax);
        chk("stall_gap", w1, 5);
        bus_write(20'h4, 32'd0);
        rd_reg("stall_reg", 20'h4, 32'd0);

        // Fixed burst to word 1
        do_burst(BASE + 32'h8, 4'd2, 1'b1, 1'b1, 64'hA, 8'hFF, 1'b0, w0, wmax);
        rd_mem("fixed_word1", 20'h10008, 32'hC);
        chk_word(0);
        chk_word(2);

        // Partial byte enables on word 0x40
        do_burst(BASE + 32'h200, 4'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, w0, wmax);
        do_burst(BASE + 32'h200, 4'd0, 1'b0, 1'b1, 64'd0, 8'h0F, 1'b0, w0, wmax);
        rd_mem("wsel_lo", 20'h10200, 32'h0);
        rd_mem("wsel_hi", 20'h10204, 32'hFFFF_FFFF);
        do_burst(BASE + 32'h208, 4'd0, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, w0, wmax);
        chk_word(65);

        // Burst straddling the window end
        bus_write(20'h0, 32'h3);
        do_burst(BASE + 32'(8 * (NW - 1)), 4'd1, 1'b0, 1'b0, 64'd0, 8'hFF, 1'b0, w0, wmax);
        rd_reg("straddle_errors", 20'h10, 32'd1);
        rd_reg("straddle_beats", 20'h8, 32'd2);
        chk_word(NW - 1);

        // Bus corner cases: unmapped reads, ignored writes into the RAM window
        rd_reg("unmapped_reg", 20'h18, 32'd0);
        rd_reg("unmapped_far", 20'h30000, 32'd0);
        bus_write(20'h10000, 32'hDEAD_BEEF);
        bus_write(20'h0FFF0, 32'h1234_5678);
        chk_word(0);

        // Random bursts
        for (int n = 0; n < 40; n++) begin
            if (n % 10 == 0) bus_write(20'h4, 32'($urandom_range(0, 3)));
            case ($urandom_range(0, 3))
                0, 1:    start = BASE + 32'($urandom_range(0, 8 * NW - 1));
                2:       start = BASE + 32'(8 * NW) - 32'($urandom_range(0, 64));
                default: start = $urandom;
            endcase
            do_burst(start, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 64'd0,
                     8'h00, 1'b1, w0, wmax);
            chk("rand_inburst_wait", wmax, 0);
        end
        chk_stats("rand");
        for (int n = 0; n < 16; n++) chk_word($urandom_range(0, NW - 1));

        // Disable: wrdy drops once idle
        bus_write(20'h4, 32'd0);
        repeat (5) @(negedge sys_clk);
        bus_write(20'h0, 32'h0);
        chk("disable_rdy", axi_wrdy_o, 0);

        // Reset after 2 of 8 beats
        bus_write(20'h0, 32'h1);
        start = BASE + 32'(8 * 300);
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            send_beat(start, {32'hC0DE_0000 | 32'(i), d}, 8'hFF, 4'd7, 1'b0, w0, ok);
            if (ok) begin
                model_beat(start + 32'(8 * i), {32'hC0DE_0000 | 32'(i), d}, 8'hFF, i == 0, start, oob);
                chk("rst_burst_werr", axi_werr_o, oob);
            end
        end
        sys_rst_i = 1'b1;
        @(negedge sys_clk);
        sys_rst_i = 1'b0;
        model_reset();
        chk("midburst_rst_wrdy", axi_wrdy_o, 0);
        @(negedge sys_clk);
        chk("post_rst_wrdy", axi_wrdy_o, 0);
        chk_stats("midrst");
        rd_reg("midrst_ctrl", 20'h0, 32'd0);
        chk_word(300);
        chk_word(301);
        chk_word(302);
        bus_read(20'h10000 + 20'(8 * 301) + 20'h4, d, lat);
        chk("midrst_word301_hi", d, 32'hC0DE_0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
